// File: rtl/prog_loader_if.sv
// Byte-stream handshake, instruction-memory write port and boot status of the program loader.
// slave: the loader; master: the byte source / SoC side.
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: assembles big-endian words from a length-prefixed byte stream into instruction memory,
// holding the CPU in reset until loaded. Define PROG_LOADER_CHECKSUM_EN for an XOR checksum trailer byte.
module prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic         clk,
    input logic         reset,
    prog_loader_if.slave bus
);

    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, CHK, DONE, ERROR} state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = CHK;
`else
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t             state_q, state_d;
    logic [15:0]        n_q;
    logic [IDX_W-1:0]   widx_q;
    logic [1:0]         bidx_q;
    logic [23:0]        shift_q;
    logic               in_ready_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               cpu_reset_q;
    logic               done_q;
    logic               error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    logic        accept;
    logic [15:0] n_hdr;
    logic        word_done;
    logic        last_word;

    assign accept    = bus.in_valid && in_ready_q;
    assign n_hdr     = {n_q[15:8], bus.in_data};
    assign word_done = (state_q == PAYLOAD) && accept && (bidx_q == 2'd3);
    assign last_word = (32'(widx_q) + 32'd1) == 32'(n_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HDR_HI;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI:  if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (32'(n_hdr) > MAX_WORDS) state_d = ERROR;
                    else if (n_hdr == 16'd0)    state_d = AFTER_PAYLOAD;
                    else                        state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (word_done && last_word) state_d = AFTER_PAYLOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:     if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
`endif
            default: ;
        endcase
    end

    // Header/word assembly, write strobe and sticky status; all hold while in_valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q         <= 16'd0;
            widx_q      <= '0;
            bidx_q      <= 2'd0;
            shift_q     <= 24'd0;
            in_ready_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= 32'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    HDR_HI: n_q[15:8] <= bus.in_data;
                    HDR_LO: n_q[7:0]  <= bus.in_data;
                    PAYLOAD: begin
                        bidx_q  <= bidx_q + 2'd1;
                        shift_q <= {shift_q[15:0], bus.in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ bus.in_data;
`endif
                        if (bidx_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= {shift_q, bus.in_data};
                            addr_q  <= BASE_ADDR + (32'(widx_q) << 2);
                            widx_q  <= widx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            in_ready_q <= (state_d != DONE) && (state_d != ERROR);
            if (state_d == DONE)  done_q  <= 1'b1;
            if (state_d == ERROR) error_q <= 1'b1;
            // Release the CPU one cycle into DONE, after any final write has landed.
            if (state_q == DONE)  cpu_reset_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (ADDR_W=2 so the word limit is 4); checksum tests run when
// PROG_LOADER_CHECKSUM_EN is defined, and every stream then carries its trailer byte.
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    prog_loader_if bus();

    prog_loader #(.ADDR_W(2), .BASE_ADDR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: imem_we is high for exactly one cycle per word.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa.push_back(bus.imem_addr);
            wd.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr(input int i, input bit data);
        if (i < wa.size()) return data ? wd[i] : wa[i];
        return 'x;
    endfunction

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hA5;
    endtask

    // Returns at the negedge right after the last byte was accepted, with in_valid low.
    task automatic send(input bq_t q, input bit gaps);
        foreach (q[i]) begin
            put(q[i]);
            if (gaps) idle();
        end
        if (!gaps) idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 1'b0;
    endtask

    task automatic check_two_word(input string tag);
        // Negedge right after the last accepted byte.
`ifndef PROG_LOADER_CHECKSUM_EN
        chk({tag, "_pulse"}, 32'(bus.imem_we), 32'd1);
`endif
        chk({tag, "_cpurst_hold"}, 32'(bus.cpu_reset), 32'd1);
        idle();
        chk({tag, "_cpurst_rel"}, 32'(bus.cpu_reset), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_error"}, 32'(bus.error), 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        repeat (2) idle();
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
        chk({tag, "_a0"}, wr(0, 1'b0), 32'h0000_0000);
        chk({tag, "_d0"}, wr(0, 1'b1), 32'h2008_0005);
        chk({tag, "_a1"}, wr(1, 1'b0), 32'h0000_0004);
        chk({tag, "_d1"}, wr(1, 1'b1), 32'hAC09_0004);
    endtask

    initial begin
        bq_t two_word;
        bq_t four_word;
        bq_t zero_len;
        bq_t new_word;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        two_word  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h04};
        four_word = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                      8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        zero_len  = '{8'h00, 8'h00};
        new_word  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef PROG_LOADER_CHECKSUM_EN
        two_word.push_back(8'h8C);
        four_word.push_back(8'h10);
        zero_len.push_back(8'h00);
        new_word.push_back(8'h22);
`endif

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0000_0000);
        chk("rst_wdata", bus.imem_wdata, 32'h0000_0000);

        // Two words, streaming
        send(two_word, 1'b0);
        check_two_word("stream");

        // Same program with in_valid toggling every cycle
        do_reset();
        send(two_word, 1'b1);
        check_two_word("stall");

        // Oversize header: 5 words > 4
        do_reset();
        put(8'h00);
        put(8'h05);
        idle();
        chk("over_error", 32'(bus.error), 32'd1);
        chk("over_ready", 32'(bus.in_ready), 32'd0);
        chk("over_cpurst", 32'(bus.cpu_reset), 32'd1);
        put(8'h11);
        put(8'h22);
        repeat (3) idle();
        chk("over_nwrites", 32'(wa.size()), 32'd0);
        chk("over_done", 32'(bus.done), 32'd0);
        chk("over_cpurst_late", 32'(bus.cpu_reset), 32'd1);

        // Exactly full memory: 4 words, last address 0x0C
        do_reset();
        send(four_word, 1'b0);
        repeat (3) idle();
        chk("full_nwrites", 32'(wa.size()), 32'd4);
        chk("full_d0", wr(0, 1'b1), 32'h0102_0304);
        chk("full_a3", wr(3, 1'b0), 32'h0000_000C);
        chk("full_d3", wr(3, 1'b1), 32'h0D0E_0F10);
        chk("full_done", 32'(bus.done), 32'd1);
        chk("full_error", 32'(bus.error), 32'd0);
        chk("full_cpurst", 32'(bus.cpu_reset), 32'd0);

        // Zero-length program
        do_reset();
        send(zero_len, 1'b0);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_cpurst_hold", 32'(bus.cpu_reset), 32'd1);
        idle();
        chk("zero_cpurst_rel", 32'(bus.cpu_reset), 32'd0);
        chk("zero_nwrites", 32'(wa.size()), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum trailer good / bad for 12 34 56 78 (XOR = 08)
        do_reset();
        send('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 1'b0);
        repeat (2) idle();
        chk("csum_ok_done", 32'(bus.done), 32'd1);
        chk("csum_ok_error", 32'(bus.error), 32'd0);
        chk("csum_ok_cpurst", 32'(bus.cpu_reset), 32'd0);
        chk("csum_ok_d0", wr(0, 1'b1), 32'h1234_5678);
        do_reset();
        send('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 1'b0);
        repeat (2) idle();
        chk("csum_bad_error", 32'(bus.error), 32'd1);
        chk("csum_bad_done", 32'(bus.done), 32'd0);
        chk("csum_bad_cpurst", 32'(bus.cpu_reset), 32'd1);
        chk("csum_bad_ready", 32'(bus.in_ready), 32'd0);
`endif

        // Reset after 3 payload bytes, then a fresh one-word load
        do_reset();
        put(8'h00);
        put(8'h01);
        put(8'h12);
        put(8'h34);
        put(8'h56);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_cpurst", 32'(bus.cpu_reset), 32'd1);
        chk("mid_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_we", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 1'b0;
        send(new_word, 1'b0);
        repeat (3) idle();
        chk("mid_nwrites", 32'(wa.size()), 32'd1);
        chk("mid_a0", wr(0, 1'b0), 32'h0000_0000);
        chk("mid_d0", wr(0, 1'b1), 32'hDEAD_BEEF);
        chk("mid_done", 32'(bus.done), 32'd1);
        chk("mid_cpurst_rel", 32'(bus.cpu_reset), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
